// File: rtl/osd_string_scheduler_pkg.sv
// osd_string_scheduler_pkg: shared FSM encoding and width/index helpers for the OSD string scheduler.
package osd_string_scheduler_pkg;

    typedef enum logic [2:0] {IDLE, ARB, WAIT_FS, FIRE, HOLD} state_t;

    function automatic int xw(input int frame_w);
        return $clog2(frame_w - 2) + 1;
    endfunction

    function automatic int yw(input int frame_h);
        return $clog2(frame_h - 2) + 1;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/osd_string_scheduler_if.sv
// osd_string_scheduler_if: requester, frame-timing and renderer-side signals of the OSD string scheduler.
interface osd_string_scheduler_if #(
    parameter int NREQ          = 4,
    parameter int STRING_LENGTH = 4,
    parameter int CHAR_ENCODING = 8,
    parameter int DATA_WIDTH    = 24,
    parameter int FRAME_W       = 640,
    parameter int FRAME_H       = 480
);
    localparam int SW = STRING_LENGTH * CHAR_ENCODING;
    localparam int CW = STRING_LENGTH * DATA_WIDTH;
    localparam int XW = osd_string_scheduler_pkg::xw(FRAME_W);
    localparam int YW = osd_string_scheduler_pkg::yw(FRAME_H);
    localparam int GW = osd_string_scheduler_pkg::idw(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*SW-1:0] req_str;
    logic [NREQ*CW-1:0] req_color;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ*YW-1:0] req_y;
    logic [NREQ-1:0]    req_ack;
    logic               frame_start;
    logic               osd_busy;
    logic               read;
    logic [SW-1:0]      str;
    logic [CW-1:0]      str_color;
    logic [XW-1:0]      start_x;
    logic [YW-1:0]      start_y;
    logic [GW-1:0]      grant_id;
    logic               active;

    modport master (
        output req_valid, req_str, req_color, req_x, req_y, frame_start, osd_busy,
        input  req_ack, read, str, str_color, start_x, start_y, grant_id, active
    );

    modport slave (
        input  req_valid, req_str, req_color, req_x, req_y, frame_start, osd_busy,
        output req_ack, read, str, str_color, start_x, start_y, grant_id, active
    );

endinterface

// File: rtl/osd_string_scheduler_rr_arbiter.sv
// osd_string_scheduler_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module osd_string_scheduler_rr_arbiter
    import osd_string_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [GW-1:0]   idx,
    output logic            any
);

    logic [GW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = GW'((int'(ptr) + i) % NREQ);
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = j;
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_string_scheduler.sv
// osd_string_scheduler: round-robin sharing of one OSD string renderer, frame-aligned load and multi-frame hold.
module osd_string_scheduler
    import osd_string_scheduler_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int STRING_LENGTH = 4,
    parameter int CHAR_ENCODING = 8,
    parameter int DATA_WIDTH    = 24,
    parameter int FRAME_W       = 640,
    parameter int FRAME_H       = 480,
    parameter int HOLD_FRAMES   = 2
) (
    input logic                   sys_clk,
    input logic                   rstb,
    osd_string_scheduler_if.slave bus
);

    localparam int SW = STRING_LENGTH * CHAR_ENCODING;
    localparam int CW = STRING_LENGTH * DATA_WIDTH;
    localparam int XW = xw(FRAME_W);
    localparam int YW = yw(FRAME_H);
    localparam int GW = idw(NREQ);
    localparam int HW = idw(HOLD_FRAMES);

    state_t          state;
    logic [GW-1:0]   ptr;
    logic [HW-1:0]   hold;
    logic [NREQ-1:0] gnt;
    logic [GW-1:0]   win;
    logic            any;

    osd_string_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (win),
        .any (any)
    );

    // Shadow registers move only on the grant (ARB) and the load strobe (FIRE), so the renderer never sees a mid-frame change.
    always_ff @(posedge sys_clk or negedge rstb) begin
        if (!rstb) begin
            state         <= IDLE;
            ptr           <= '0;
            hold          <= '0;
            bus.req_ack   <= '0;
            bus.read      <= 1'b0;
            bus.active    <= 1'b0;
            bus.grant_id  <= '0;
            bus.str       <= '0;
            bus.str_color <= '0;
            bus.start_x   <= '0;
            bus.start_y   <= '0;
        end else begin
            bus.req_ack <= '0;
            bus.read    <= 1'b0;
            case (state)
                IDLE: if (|bus.req_valid) state <= ARB;
                ARB: begin
                    if (any) begin
                        bus.req_ack   <= gnt;
                        bus.grant_id  <= win;
                        bus.str       <= bus.req_str[lsb(int'(win), SW) +: SW];
                        bus.str_color <= bus.req_color[lsb(int'(win), CW) +: CW];
                        bus.start_x   <= bus.req_x[lsb(int'(win), XW) +: XW];
                        bus.start_y   <= bus.req_y[lsb(int'(win), YW) +: YW];
                        ptr           <= (win == GW'(NREQ - 1)) ? '0 : win + GW'(1);
                        state         <= WAIT_FS;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_FS: begin
                    if (bus.frame_start && !bus.osd_busy) begin
                        bus.read   <= 1'b1;
                        bus.active <= 1'b1;
                        hold       <= HW'(HOLD_FRAMES - 1);
                        state      <= FIRE;
                    end
                end
                FIRE: state <= HOLD;
                HOLD: begin
                    if (bus.frame_start) begin
                        if (hold != '0) hold <= hold - HW'(1);
                        else if (|bus.req_valid) state <= ARB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_string_scheduler.sv
// tb_osd_string_scheduler: directed table, hand sequences and random traffic against a frame-level reference model.
module tb_osd_string_scheduler;

    localparam int NREQ = 4;
    localparam int HF   = 2;
    localparam int SW   = 32;
    localparam int CW   = 96;
    localparam int XW   = 11;
    localparam int YW   = 10;

    localparam int M_REQ   = 0;
    localparam int M_ARB   = 1;
    localparam int M_FRAME = 2;
    localparam int M_FIRE  = 3;
    localparam int M_SHOW  = 4;

    typedef struct {
        logic [3:0] v;
        logic       fs;
        logic       busy;
        logic [3:0] ack;
        logic       rd;
        logic       act;
    } vec_t;

    logic sys_clk = 1'b0;
    logic rstb    = 1'b1;
    always #5 sys_clk = ~sys_clk;

    osd_string_scheduler_if #(
        .NREQ(NREQ), .STRING_LENGTH(4), .CHAR_ENCODING(8), .DATA_WIDTH(24), .FRAME_W(640), .FRAME_H(480)
    ) bus ();

    osd_string_scheduler #(
        .NREQ(NREQ), .STRING_LENGTH(4), .CHAR_ENCODING(8), .DATA_WIDTH(24), .FRAME_W(640), .FRAME_H(480),
        .HOLD_FRAMES(HF)
    ) dut (
        .sys_clk (sys_clk),
        .rstb    (rstb),
        .bus     (bus)
    );

    logic [SW-1:0]   f_str [NREQ];
    logic [CW-1:0]   f_col [NREQ];
    logic [XW-1:0]   f_x   [NREQ];
    logic [YW-1:0]   f_y   [NREQ];
    logic [NREQ-1:0] v    = '0;
    logic            fs   = 1'b0;
    logic            busy = 1'b0;

    assign bus.req_valid   = v;
    assign bus.frame_start = fs;
    assign bus.osd_busy    = busy;
    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign bus.req_str[g*SW +: SW]   = f_str[g];
        assign bus.req_color[g*CW +: CW] = f_col[g];
        assign bus.req_x[g*XW +: XW]     = f_x[g];
        assign bus.req_y[g*YW +: YW]     = f_y[g];
    end

    int n_chk = 0;
    int n_err = 0;
    int d_rd  = 0;
    int d_ack = 0;
    int m_rd  = 0;

    int            mode;
    int            m_ptr;
    int            m_left;
    logic [3:0]    m_ack;
    logic          m_read;
    logic          m_active;
    logic [1:0]    m_gid;
    logic [SW-1:0] m_str;
    logic [CW-1:0] m_col;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        logic [1:0] k;
        for (int i = 0; i < NREQ; i++) begin
            k = 2'((p + i) % NREQ);
            if (r[k]) return int'(k);
        end
        return -1;
    endfunction

    task automatic model_reset();
        mode = M_REQ; m_ptr = 0; m_left = 0;
        m_ack = '0; m_read = 1'b0; m_active = 1'b0; m_gid = '0;
        m_str = '0; m_col = '0; m_x = '0; m_y = '0;
    endtask

    // Advances the reference by one clock edge, using the inputs presented to that edge.
    task automatic model_step();
        int w;
        m_ack  = '0;
        m_read = 1'b0;
        if (!rstb) begin
            model_reset();
            return;
        end
        case (mode)
            M_REQ: if (|v) mode = M_ARB;
            M_ARB: begin
                w = pick(v, m_ptr);
                if (w < 0) mode = M_REQ;
                else begin
                    m_ack = 4'(1 << w); m_gid = 2'(w);
                    m_str = f_str[w]; m_col = f_col[w]; m_x = f_x[w]; m_y = f_y[w];
                    m_ptr = (w + 1) % NREQ;
                    mode  = M_FRAME;
                end
            end
            M_FRAME: if (fs && !busy) begin
                m_read = 1'b1; m_active = 1'b1; m_left = HF; m_rd++;
                mode = M_FIRE;
            end
            M_FIRE: mode = M_SHOW;
            M_SHOW: if (fs) begin
                if (m_left > 1) m_left--;
                else if (|v) mode = M_ARB;
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        chk("ctrl", 128'({bus.req_ack, bus.read, bus.active, bus.grant_id}), 128'({m_ack, m_read, m_active, m_gid}));
        chk("pos_str", 128'({bus.start_x, bus.start_y, bus.str}), 128'({m_x, m_y, m_str}));
        chk("color", 128'(bus.str_color), 128'(m_col));
    endtask

    task automatic tick();
        model_step();
        @(posedge sys_clk);
        #1;
        compare();
        if (bus.read) d_rd++;
        if (|bus.req_ack) d_ack++;
    endtask

    task automatic do_reset();
        v = '0; fs = 1'b0; busy = 1'b0;
        #2 rstb = 1'b0;
        #1;
        chk("async_rst", 128'({bus.req_ack, bus.read, bus.active, bus.grant_id, bus.start_x, bus.start_y, bus.str}), 128'(0));
        chk("async_rst_color", 128'(bus.str_color), 128'(0));
        model_reset();
        tick();
        tick();
        rstb = 1'b1;
    endtask

    // Frame pulse every 8 cycles for n cycles.
    task automatic run_frames(input int n);
        for (int c = 0; c < n; c++) begin
            fs = (c % 8 == 0);
            tick();
        end
        fs = 1'b0;
    endtask

    vec_t tbl [15];
    int   grants[$];
    int   gaps[$];
    int   exp_g [4] = '{0, 2, 0, 2};

    initial begin
        int rd0, ack0, fs_cnt, period, cnt;
        bit seen;
        for (int i = 0; i < NREQ; i++) begin
            f_str[i] = $urandom;
            f_col[i] = {$urandom, $urandom, $urandom};
            f_x[i]   = 11'($urandom_range(0, 637));
            f_y[i]   = 10'($urandom_range(0, 477));
        end
        model_reset();

        tbl[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        tbl[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[10] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[11] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1};
        tbl[12] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1};
        tbl[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};

        // Single requester 0: same-cycle frame_start ignored, busy deferral, hold, re-grant of the sole requester.
        f_str[0] = 32'h3031_20B0; f_x[0] = 11'd1; f_y[0] = 10'd1;
        do_reset();
        for (int r = 0; r < 15; r++) begin
            v = tbl[r].v; fs = tbl[r].fs; busy = tbl[r].busy;
            tick();
            chk($sformatf("tbl%0d", r), 128'({bus.req_ack, bus.read, bus.active}), 128'({tbl[r].ack, tbl[r].rd, tbl[r].act}));
            if (r == 1) chk("req0_fields", 128'({bus.start_x, bus.start_y, bus.str}), 128'({11'd1, 10'd1, 32'h3031_20B0}));
        end
        fs = 1'b0; busy = 1'b0;

        // Requesters 0 and 2 alternate, each held for HF frames.
        do_reset();
        v = 4'b0101;
        fs_cnt = 0; seen = 0; rd0 = d_rd; ack0 = d_ack;
        for (int c = 0; c < 112; c++) begin
            fs = (c % 8 == 0);
            tick();
            if (fs) fs_cnt++;
            if (|bus.req_ack) grants.push_back(int'(bus.grant_id));
            if (bus.read) begin
                if (seen) gaps.push_back(fs_cnt);
                seen = 1; fs_cnt = 0;
            end
        end
        fs = 1'b0;
        chk("rr_ngrants", 128'(grants.size()), 128'(5));
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 128'(grants[i]), 128'(exp_g[i]));
        chk("rr_reads_per_grant", 128'(d_rd - rd0), 128'(d_ack - ack0));
        chk("rr_ngaps", 128'(gaps.size()), 128'(4));
        foreach (gaps[i]) chk($sformatf("rr_gap%0d", i), 128'(gaps[i]), 128'(HF + 1));

        // Reset while holding a string at (300,250).
        do_reset();
        f_x[1] = 11'd300; f_y[1] = 10'd250;
        v = 4'b0010;
        run_frames(13);
        chk("hold_pos", 128'({bus.active, bus.start_x, bus.start_y}), 128'({1'b1, 11'd300, 10'd250}));
        do_reset();
        rd0 = d_rd;
        run_frames(40);
        chk("no_read_after_rst", 128'(d_rd - rd0), 128'(0));
        v = 4'b0010; ack0 = d_ack;
        run_frames(17);
        chk("regrant_ack", 128'(d_ack - ack0), 128'(1));
        chk("regrant_read", 128'(d_rd - rd0), 128'(1));

        // All requesters drop after the grant: display persists, nothing else issued.
        do_reset();
        v = 4'b1000; rd0 = d_rd; ack0 = d_ack;
        for (int c = 0; c < 16; c++) begin
            fs = (c % 8 == 0);
            tick();
            if (c == 2) v = '0;
        end
        run_frames(41);
        chk("drop_acks", 128'(d_ack - ack0), 128'(1));
        chk("drop_reads", 128'(d_rd - rd0), 128'(1));
        chk("drop_hold", 128'({bus.active, bus.grant_id, bus.start_x, bus.start_y, bus.str}), 128'({1'b1, 2'd3, f_x[3], f_y[3], f_str[3]}));
        chk("drop_color", 128'(bus.str_color), 128'(f_col[3]));

        // Random traffic against the reference model.
        do_reset();
        rd0 = d_rd; m_rd = 0; cnt = 0; period = 5;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) v[$urandom_range(0, NREQ - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) f_str[$urandom_range(0, NREQ - 1)] = $urandom;
            if ($urandom_range(0, 15) == 0) f_x[$urandom_range(0, NREQ - 1)] = 11'($urandom_range(0, 637));
            fs = (cnt == 0);
            busy = ($urandom_range(0, 3) == 0);
            cnt = (cnt == period) ? 0 : cnt + 1;
            if (fs) period = $urandom_range(3, 10);
            tick();
        end
        fs = 1'b0; busy = 1'b0;
        chk("rand_reads", 128'(d_rd - rd0), 128'(m_rd));
        chk("rand_activity", 128'(m_rd > 20), 128'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
